// File: rtl/timer_ctrl.sv
// timer_ctrl: debounced start/stop + clear buttons sequencing a stopwatch (IDLE/RUNNING/PAUSED/FULL)
// with a gated 1/TICK_HZ prescaler and a BCD M:SS.t count; optional display lap-freeze under LAP_EN.
// Latency: button edge to state change = 2 sync + DEB_CYCLES + 1 cycles; no backpressure, inputs sampled every cycle.
module timer_ctrl #(
  parameter int CLK_HZ     = 12000000,
  parameter int TICK_HZ    = 10,
  parameter int DEB_CYCLES = 120000,
  parameter int MAX_MIN    = 9
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        BTN_SS,
  input  logic        BTN_CLR,
  output logic        RUN,
  output logic        TICK,
  output logic        OVF,
  output logic        LAP_ACTIVE,
  output logic [15:0] DISP_DIGITS
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DW  = $clog2(DEB_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, FULL} state_t;

  state_t          state, state_n;
  logic            clr_count;
  logic [1:0]      sync1, sync2, deb, deb_q;
  logic [DW-1:0]   deb_cnt [2];
  logic            ss_p, clr_p;
  logic [PW-1:0]   presc;
  logic [3:0]      d_min, d_sten, d_sunit, d_tenth;
  logic [15:0]     count;
  logic            at_max;
  logic            run_q;

  // Two-flop synchronisers plus per-button stability counters; bit 0 = start/stop, bit 1 = clear.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= {BTN_CLR, BTN_SS};
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != deb[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            deb[i]     <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign ss_p  = deb[0] & ~deb_q[0];
  assign clr_p = deb[1] & ~deb_q[1];

  assign count  = {d_min, d_sten, d_sunit, d_tenth};
  assign at_max = (d_min == 4'(MAX_MIN)) && (d_sten == 4'd5) && (d_sunit == 4'd9) && (d_tenth == 4'd9);
  assign TICK   = (state == RUNNING) && (presc == PRESC_LAST);
  assign OVF    = TICK && at_max;
  assign RUN    = run_q;

  // Next-state logic; reaching the count ceiling wins over a simultaneous start/stop press.
  always_comb begin
    state_n   = state;
    clr_count = 1'b0;
    case (state)
      IDLE:    if (ss_p) state_n = RUNNING;
      RUNNING: begin
        if (TICK && at_max) state_n = FULL;
        else if (ss_p)      state_n = PAUSED;
      end
      PAUSED: begin
        if (clr_p) begin
          state_n   = IDLE;
          clr_count = 1'b1;
        end else if (ss_p) begin
          state_n = RUNNING;
        end
      end
      FULL: begin
        if (clr_p) begin
          state_n   = IDLE;
          clr_count = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register; RUN is registered from the next state so it lines up with the state itself.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      run_q <= 1'b0;
    end else begin
      state <= state_n;
      run_q <= (state_n == RUNNING);
    end
  end

  // Prescaler: counts while running, holds the fractional period while paused, clears otherwise.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      presc <= '0;
    end else if (state == RUNNING) begin
      presc <= TICK ? '0 : presc + 1'b1;
    end else if (state != PAUSED) begin
      presc <= '0;
    end
  end

  // BCD cascade; saturates at the ceiling instead of wrapping.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      {d_min, d_sten, d_sunit, d_tenth} <= '0;
    end else if (clr_count) begin
      {d_min, d_sten, d_sunit, d_tenth} <= '0;
    end else if (TICK && !at_max) begin
      if (d_tenth != 4'd9) begin
        d_tenth <= d_tenth + 4'd1;
      end else begin
        d_tenth <= 4'd0;
        if (d_sunit != 4'd9) begin
          d_sunit <= d_sunit + 4'd1;
        end else begin
          d_sunit <= 4'd0;
          if (d_sten != 4'd5) begin
            d_sten <= d_sten + 4'd1;
          end else begin
            d_sten <= 4'd0;
            d_min  <= d_min + 4'd1;
          end
        end
      end
    end
  end

`ifdef LAP_EN
  logic        lap_q;
  logic [15:0] snap;

  // Lap freeze: clear toggles it while running; any exit from RUNNING drops it the same cycle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      lap_q <= 1'b0;
      snap  <= '0;
    end else if (state_n != RUNNING) begin
      lap_q <= 1'b0;
    end else if ((state == RUNNING) && clr_p && !ss_p) begin
      lap_q <= ~lap_q;
      if (!lap_q) snap <= count;
    end
  end

  assign LAP_ACTIVE  = lap_q;
  assign DISP_DIGITS = lap_q ? snap : count;
`else
  assign LAP_ACTIVE  = 1'b0;
  assign DISP_DIGITS = count;
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed bench for timer_ctrl at CLK_HZ=100, TICK_HZ=10, DEB_CYCLES=4, MAX_MIN=0.
// Expected values are hand-derived cycle counts and a tenths counter driven by observed TICKs.
// Outputs are sampled on the falling edge; buttons change just after a falling edge.
module tb_timer_ctrl;
  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        BTN_SS = 1'b0;
  logic        BTN_CLR = 1'b0;
  logic        RUN, TICK, OVF, LAP_ACTIVE;
  logic [15:0] DISP_DIGITS;

  int n_checks = 0;
  int n_fail   = 0;
  int model    = 0;   // tenths counted from observed TICKs
  int disp_exp = 0;   // what the display should show at the current sample

  timer_ctrl #(.CLK_HZ(100), .TICK_HZ(10), .DEB_CYCLES(4), .MAX_MIN(0)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .BTN_SS(BTN_SS), .BTN_CLR(BTN_CLR),
    .RUN(RUN), .TICK(TICK), .OVF(OVF), .LAP_ACTIVE(LAP_ACTIVE), .DISP_DIGITS(DISP_DIGITS)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] bcd(input int c);
    int s;
    s = (c / 10) % 60;
    return {4'(c / 600), 4'(s / 10), 4'(s % 10), 4'(c % 10)};
  endfunction

  task automatic step();
    @(negedge CLK);
    disp_exp = model;
    if (TICK === 1'b1 && OVF !== 1'b1) model++;
  endtask

  task automatic press(input logic ss, input logic clr);
    BTN_SS  = ss;
    BTN_CLR = clr;
    fork
      begin
        repeat (8) @(negedge CLK);
        BTN_SS  = 1'b0;
        BTN_CLR = 1'b0;
      end
    join_none
  endtask

  task automatic wait_run(input string tag);
    int n;
    n = 0;
    while (RUN !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check(tag, RUN, 1);
  endtask

  task automatic wait_tick(output int k);
    k = 1;
    while (TICK !== 1'b1 && k < 40) begin
      step();
      k++;
    end
  endtask

  initial begin
    int  k, n;
    bit  found, pend, seen;

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_run", RUN, 0);
    check("rst_tick", TICK, 0);
    check("rst_ovf", OVF, 0);
    check("rst_lap", LAP_ACTIVE, 0);
    check("rst_disp", DISP_DIGITS, 16'h0000);
    RESET_N = 1'b1;
    step();

    // Short glitch is rejected by the debouncer
    BTN_SS = 1'b1;
    repeat (2) @(negedge CLK);
    BTN_SS = 1'b0;
    repeat (20) step();
    check("glitch_run", RUN, 0);
    check("glitch_disp", DISP_DIGITS, 16'h0000);

    // Start and count
    press(1'b1, 1'b0);
    wait_run("start_run");
    wait_tick(k);
    check("first_tick_lat", k, 10);
    repeat (20) step();
    check("tick_at_30", TICK, 1);
    press(1'b1, 1'b0);            // pause lands with prescaler = 6
    repeat (5) step();
    check("run_at_35", RUN, 1);
    check("disp_0003", DISP_DIGITS, 16'h0003);
    check("ticks_3", model, 3);
    n = 0;
    while (RUN === 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("pause_lat", n, 2);

    // Paused holds
    repeat (50) step();
    check("pause_run", RUN, 0);
    check("pause_disp", DISP_DIGITS, 16'h0003);
    check("pause_ticks", model, 3);

    // Resume keeps fractional period
    press(1'b1, 1'b0);
    wait_run("resume_run");
    wait_tick(k);
    check("resume_lat", k, 4);
    step();
    check("disp_0004", DISP_DIGITS, 16'h0004);

    // Run to the ceiling
    found = 0;
    pend  = 0;
    for (int i = 0; i < 7000 && !found; i++) begin
      step();
      if (pend && (disp_exp == 10 || disp_exp == 60 || disp_exp == 100 || disp_exp == 599))
        check($sformatf("bcd_%0d", disp_exp), DISP_DIGITS, bcd(disp_exp));
      pend = (TICK === 1'b1);
      if (OVF === 1'b1) begin
        found = 1;
        check("ovf_with_tick", TICK, 1);
        check("ovf_at_599", disp_exp, 599);
        check("full_disp", DISP_DIGITS, 16'h0599);
      end
    end
    check("ovf_seen", found, 1);
    step();
    check("ovf_one_cycle", OVF, 0);
    check("full_run", RUN, 0);

    // FULL ignores start/stop, clear returns to IDLE
    press(1'b1, 1'b0);
    repeat (20) step();
    check("full_ss_run", RUN, 0);
    check("full_ss_disp", DISP_DIGITS, 16'h0599);
    press(1'b0, 1'b1);
    repeat (20) step();
    model = 0;
    check("full_clr_disp", DISP_DIGITS, 16'h0000);
    check("full_clr_run", RUN, 0);

    // Simultaneous press in PAUSED: clear wins
    press(1'b1, 1'b0);
    repeat (25) step();
    check("run2", RUN, 1);
    press(1'b1, 1'b0);
    repeat (20) step();
    check("paused2_run", RUN, 0);
    check("paused2_disp", DISP_DIGITS, bcd(disp_exp));
    press(1'b1, 1'b1);
    seen = 0;
    repeat (20) begin
      step();
      if (RUN === 1'b1) seen = 1;
    end
    model = 0;
    check("simul_run", seen, 0);
    check("simul_disp", DISP_DIGITS, 16'h0000);
    press(1'b1, 1'b0);
    wait_run("restart_run");
    wait_tick(k);
    check("restart_lat", k, 10);

    // Clear while running
    n = 0;
    while (model < 12 && n < 200) begin
      step();
      n++;
    end
    step();
    check("pre_lap", DISP_DIGITS, 16'h0012);
    press(1'b0, 1'b1);
    repeat (30) step();
    check("lap_ticks", model, 15);
`ifdef LAP_EN
    check("lap_active", LAP_ACTIVE, 1);
    check("lap_frozen", DISP_DIGITS, 16'h0012);
`else
    check("lap_active", LAP_ACTIVE, 0);
    check("lap_live", DISP_DIGITS, bcd(disp_exp));
`endif
    press(1'b0, 1'b1);
    repeat (20) step();
    check("lap_release", LAP_ACTIVE, 0);
    check("lap_release_disp", DISP_DIGITS, bcd(disp_exp));
    check("lap_run", RUN, 1);

    // Asynchronous reset mid-run
    RESET_N = 1'b0;
    #1;
    check("mid_rst_run", RUN, 0);
    check("mid_rst_disp", DISP_DIGITS, 16'h0000);
    repeat (2) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
